// File: rtl/add_operand_sequencer_pkg.sv
// Shared definitions for the add operand sequencer: state encoding and the
// default byte width.
package add_operand_sequencer_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    OUT    = 2'd2
  } state_e;

endpackage : add_operand_sequencer_pkg

// File: rtl/add_operand_sequencer_add_core.sv
// Combinational byte adder {cout, sum} = a + b + cin; kept behind a fixed
// port list so a carry-select version can drop in unchanged.
module add_core #(
  parameter int WIDTH = add_operand_sequencer_pkg::WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  logic [WIDTH:0] full_sum;

  assign full_sum       = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
  assign {cout_o, sum_o} = full_sum;

endmodule : add_core

// File: rtl/add_operand_sequencer.sv
// Collects operand A then B from a shared byte lane, adds them with a chained
// carry, and offers the registered sum downstream over valid/ready.
module add_operand_sequencer
  import add_operand_sequencer_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEFAULT,
  parameter bit CARRY_CHAIN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] core_sum;
  logic             core_cout;
  logic             cin_eff;

  assign cin_eff = CARRY_CHAIN ? carry_q : 1'b0;

  add_core #(.WIDTH(WIDTH)) u_add_core (
    .a_i   (a_q),
    .b_i   (in_data),
    .cin_i (cin_eff),
    .sum_o (core_sum),
    .cout_o(core_cout)
  );

  // NOTE: every signal written here gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    last_d   = last_q;
    valid_d  = valid_q;
    in_ready = 1'b0;
    unique case (state_q)
      LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_data;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sum_d   = core_sum;
          cout_d  = core_cout;
          last_d  = in_last;
          valid_d = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        // The carry survives only into the next byte of the same multi-byte add.
        if (out_ready) begin
          valid_d = 1'b0;
          carry_d = (last_q || !CARRY_CHAIN) ? 1'b0 : cout_q;
          state_d = LOAD_A;
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_A;
      a_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign out_sum   = sum_q;
  assign out_carry = cout_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;
  assign busy      = (state_q != LOAD_A) || carry_q;

endmodule : add_operand_sequencer

// File: tb/tb_add_operand_sequencer.sv
// Drives a chained-carry and a no-chain instance with identical byte streams
// and compares both against arithmetic expectations.
module tb_add_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       out_ready;

  logic       in_ready0, out_carry0, out_last0, out_valid0, busy0;
  logic [7:0] out_sum0;
  logic       in_ready1, out_carry1, out_last1, out_valid1, busy1;
  logic [7:0] out_sum1;

  int checks = 0;
  int errors = 0;
  logic carry_m = 1'b0;

  always #5 clk = ~clk;

  add_operand_sequencer #(.WIDTH(8), .CARRY_CHAIN(1'b1)) dut_chain (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready0),
    .out_sum  (out_sum0),
    .out_carry(out_carry0),
    .out_last (out_last0),
    .out_valid(out_valid0),
    .out_ready(out_ready),
    .busy     (busy0)
  );

  add_operand_sequencer #(.WIDTH(8), .CARRY_CHAIN(1'b0)) dut_nochain (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready1),
    .out_sum  (out_sum1),
    .out_carry(out_carry1),
    .out_last (out_last1),
    .out_valid(out_valid1),
    .out_ready(out_ready),
    .busy     (busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", {31'd0, in_ready0}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_add(input logic [7:0] a, input logic [7:0] b, input logic l,
                        input int stall, input bit hold_valid);
    int e0;
    int e1;
    e0 = int'(a) + int'(b) + int'(carry_m);
    e1 = int'(a) + int'(b);
    send(a, 1'($urandom_range(0, 1)));
    send(b, l);
    if (hold_valid) begin
      in_valid = 1'b1;
      in_data  = 8'hEE;
      in_last  = 1'b1;
    end
    for (int i = 0; i <= stall; i++) begin
      @(negedge clk);
      check("valid0", {31'd0, out_valid0}, 32'd1);
      check("sum0", {24'd0, out_sum0}, e0 % 256);
      check("carry0", {31'd0, out_carry0}, e0 / 256);
      check("last0", {31'd0, out_last0}, {31'd0, l});
      check("sum1", {24'd0, out_sum1}, e1 % 256);
      check("carry1", {31'd0, out_carry1}, e1 / 256);
      check("valid1", {31'd0, out_valid1}, 32'd1);
      check("in_ready_out", {30'd0, in_ready0, in_ready1}, 32'd0);
      check("busy_out", {30'd0, busy0, busy1}, 32'd3);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    carry_m = l ? 1'b0 : ((e0 / 256) != 0);
    @(negedge clk);
    check("valid_drop", {30'd0, out_valid0, out_valid1}, 32'd0);
    check("busy0_after", {31'd0, busy0}, {31'd0, carry_m});
    check("busy1_after", {31'd0, busy1}, 32'd0);
    check("in_ready_after", {30'd0, in_ready0, in_ready1}, 32'd3);
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", {30'd0, out_valid0, out_valid1}, 32'd0);
    check("rst_sum", {16'd0, out_sum0, out_sum1}, 32'd0);
    check("rst_carry_last", {28'd0, out_carry0, out_last0, out_carry1, out_last1}, 32'd0);
    check("rst_busy", {30'd0, busy0, busy1}, 32'd0);
    check("rst_in_ready", {30'd0, in_ready0, in_ready1}, 32'd3);

    // Single add, then a two-byte carry chain.
    do_add(8'h3C, 8'h55, 1'b1, 0, 1'b0);
    do_add(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    do_add(8'h00, 8'h00, 1'b1, 0, 1'b0);

    // Backpressure held for five cycles.
    do_add(8'h80, 8'h80, 1'b1, 5, 1'b0);

    // Reset while waiting for B discards the partial operand and chained carry.
    do_add(8'hF0, 8'h20, 1'b0, 1, 1'b0);
    send(8'hAA, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    carry_m = 1'b0;
    @(negedge clk);
    check("midrst_state", {28'd0, busy0, busy1, in_ready0, out_valid0}, 32'd2);
    do_add(8'h01, 8'h02, 1'b1, 0, 1'b0);

    // Input held valid during OUT must not be consumed.
    do_add(8'h12, 8'h34, 1'b1, 2, 1'b1);
    do_add(8'h10, 8'h20, 1'b1, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      do_add(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_add_operand_sequencer
